// File: rtl/comp_pkg.sv
// comp_pkg: shared field widths, instruction field slicing, FSM states and packed-index helpers
package comp_pkg;
  localparam int F1_W = 7;
  localparam int F2_W = 15;
  localparam int F3_W = 10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_COMP_REQ,
    S_COMP_WAIT,
    S_DECOMP,
    S_IC_REQ,
    S_IC_WAIT,
    S_RESP
  } state_e;
  function automatic logic [F1_W-1:0] f1_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction
  function automatic logic [F2_W-1:0] f2_of(input logic [31:0] inst);
    return {inst[24:15], inst[11:7]};
  endfunction
  function automatic logic [F3_W-1:0] f3_of(input logic [31:0] inst);
    return {inst[31:25], inst[14:12]};
  endfunction
  function automatic logic [31:0] reassemble(input logic [F1_W-1:0] f1, input logic [F2_W-1:0] f2,
                                             input logic [F3_W-1:0] f3);
    return {f3[9:3], f2[14:5], f3[2:0], f2[4:0], f1};
  endfunction
  function automatic logic [31:0] idx_pack(input int f2w, input int f3w, input logic [31:0] f1,
                                           input logic [31:0] f2, input logic [31:0] f3);
    return (f1 << (f2w + f3w)) | (f2 << f3w) | f3;
  endfunction
endpackage

// File: rtl/comp_fill_fifo.sv
// comp_fill_fifo: fill FIFO with registered full/empty flags and a newest-entry address tap
module comp_fill_fifo #(
  parameter int W = 48,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [31:0]  o_newest_addr
);
  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;
  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_full, r_empty;
  assign w_cnt_n       = r_cnt + CW'(i_push) - CW'(i_pop);
  assign o_data        = r_mem[r_rp];
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_newest_addr = r_mem[r_wp - PW'(1)][W-1 -: 32];
  // pointers, occupancy and the registered full/empty flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wp    <= r_wp + PW'(i_push);
      r_rp    <= r_rp + PW'(i_pop);
      r_cnt   <= w_cnt_n;
      r_full  <= w_cnt_n == CW'(D);
      r_empty <= w_cnt_n == '0;
    end
  end
  // storage needs no reset; outputs are masked by empty at the top
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/comp_fetch_ctrl.sv
// comp_fetch_ctrl: fetch controller serving from the compressed cache or the icache; COMP_FETCH_STATS_EN adds stat counters
module comp_fetch_ctrl
  import comp_pkg::*;
#(
  parameter int F1_IDX_W   = 3,
  parameter int F2_IDX_W   = 8,
  parameter int F3_IDX_W   = 5,
  parameter int FILL_DEPTH = 4,
  localparam int IDX_W     = F1_IDX_W + F2_IDX_W + F3_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             proc_valid,
  input  logic [31:0]      proc_addr,
  output logic             proc_ready,
  output logic [31:0]      proc_rdata,
  output logic             comp_req_valid,
  output logic [31:0]      comp_req_addr,
  input  logic             comp_resp_valid,
  input  logic             comp_resp_hit,
  input  logic [IDX_W-1:0] comp_resp_idx,
  output logic             ic_req_valid,
  output logic [31:0]      ic_req_addr,
  input  logic             ic_resp_valid,
  input  logic [31:0]      ic_resp_rdata,
  output logic [IDX_W-1:0] dict_key,
  input  logic [31:0]      dict_val,
  output logic [31:0]      dict_probe,
  input  logic [2:0]       dict_probe_hit,
  input  logic [IDX_W-1:0] dict_probe_idx,
  output logic             fill_valid,
  input  logic             fill_ready,
  output logic [31:0]      fill_addr,
  output logic [IDX_W-1:0] fill_idx
`ifdef COMP_FETCH_STATS_EN
  ,
  output logic [31:0]      stat_comp_hits,
  output logic [31:0]      stat_ic_fetches,
  output logic [31:0]      stat_fill_drops
`endif
);
  state_e             r_state, w_next;
  logic [31:0]        r_addr, r_rsp, w_newest;
  logic [IDX_W-1:0]   r_idx;
  logic [31+IDX_W:0]  w_head;
  logic               w_empty, w_full, w_pop, w_req, w_push, w_ic_done, w_hit;
  assign w_hit     = r_state == S_COMP_WAIT && comp_resp_valid && comp_resp_hit;
  assign w_ic_done = r_state == S_IC_WAIT && ic_resp_valid;
  assign w_req     = w_ic_done && &dict_probe_hit && !(!w_empty && w_newest == r_addr);
  assign w_pop     = !w_empty && fill_ready;
  assign w_push    = w_req && (!w_full || w_pop);
  comp_fill_fifo #(.W(32 + IDX_W), .D(FILL_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_data       ({r_addr, dict_probe_idx}),
    .i_pop        (w_pop),
    .o_data       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_newest_addr(w_newest)
  );
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = proc_valid ? S_COMP_REQ : S_IDLE;
      S_COMP_REQ:  w_next = S_COMP_WAIT;
      S_COMP_WAIT: w_next = !comp_resp_valid ? S_COMP_WAIT : comp_resp_hit ? S_DECOMP : S_IC_REQ;
      S_DECOMP:    w_next = S_RESP;
      S_IC_REQ:    w_next = S_IC_WAIT;
      S_IC_WAIT:   w_next = ic_resp_valid ? S_RESP : S_IC_WAIT;
      default:     w_next = S_IDLE;
    endcase
  end
  // outputs decoded from state; data outputs stay zero outside their state
  always_comb begin
    proc_ready     = r_state == S_RESP;
    proc_rdata     = r_state == S_RESP ? r_rsp : '0;
    comp_req_valid = r_state == S_COMP_REQ;
    comp_req_addr  = r_state == S_COMP_REQ ? r_addr : '0;
    ic_req_valid   = r_state == S_IC_REQ;
    ic_req_addr    = r_state == S_IC_REQ ? r_addr : '0;
    dict_key       = r_state == S_DECOMP ? r_idx : '0;
    dict_probe     = r_state == S_IC_WAIT ? ic_resp_rdata : '0;
    fill_valid     = !w_empty;
    fill_addr      = w_empty ? '0 : w_head[31+IDX_W -: 32];
    fill_idx       = w_empty ? '0 : w_head[IDX_W-1:0];
  end
  // transaction address, hit index and response register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_idx  <= '0;
      r_rsp  <= '0;
    end else begin
      if (r_state == S_IDLE && proc_valid) r_addr <= proc_addr;
      if (w_hit) r_idx <= comp_resp_idx;
      if (r_state == S_DECOMP) r_rsp <= dict_val;
      if (w_ic_done) r_rsp <= ic_resp_rdata;
    end
  end
`ifdef COMP_FETCH_STATS_EN
  logic w_drop;
  assign w_drop = w_req && w_full && !w_pop;
  // saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_comp_hits  <= '0;
      stat_ic_fetches <= '0;
      stat_fill_drops <= '0;
    end else begin
      if (w_hit && ~&stat_comp_hits) stat_comp_hits <= stat_comp_hits + 32'd1;
      if (w_ic_done && ~&stat_ic_fetches) stat_ic_fetches <= stat_ic_fetches + 32'd1;
      if (w_drop && ~&stat_fill_drops) stat_fill_drops <= stat_fill_drops + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_comp_fetch_ctrl.sv
// tb_comp_fetch_ctrl: directed self-checking bench for comp_fetch_ctrl
module tb_comp_fetch_ctrl;
  import comp_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        proc_valid = 1'b0;
  logic [31:0] proc_addr = '0;
  logic        proc_ready;
  logic [31:0] proc_rdata;
  logic        comp_req_valid;
  logic [31:0] comp_req_addr;
  logic        comp_resp_valid = 1'b0;
  logic        comp_resp_hit = 1'b0;
  logic [15:0] comp_resp_idx = '0;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid = 1'b0;
  logic [31:0] ic_resp_rdata = '0;
  logic [15:0] dict_key;
  logic [31:0] dict_val = '0;
  logic [31:0] dict_probe;
  logic [2:0]  dict_probe_hit = '0;
  logic [15:0] dict_probe_idx = '0;
  logic        fill_valid;
  logic        fill_ready = 1'b0;
  logic [31:0] fill_addr;
  logic [15:0] fill_idx;
`ifdef COMP_FETCH_STATS_EN
  logic [31:0] stat_comp_hits, stat_ic_fetches, stat_fill_drops;
`endif
  int checks = 0;
  int errors = 0;
  comp_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .proc_valid(proc_valid), .proc_addr(proc_addr), .proc_ready(proc_ready), .proc_rdata(proc_rdata),
    .comp_req_valid(comp_req_valid), .comp_req_addr(comp_req_addr),
    .comp_resp_valid(comp_resp_valid), .comp_resp_hit(comp_resp_hit), .comp_resp_idx(comp_resp_idx),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_rdata(ic_resp_rdata),
    .dict_key(dict_key), .dict_val(dict_val), .dict_probe(dict_probe),
    .dict_probe_hit(dict_probe_hit), .dict_probe_idx(dict_probe_idx),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_idx(fill_idx)
`ifdef COMP_FETCH_STATS_EN
    , .stat_comp_hits(stat_comp_hits), .stat_ic_fetches(stat_ic_fetches), .stat_fill_drops(stat_fill_drops)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic miss(input logic [31:0] a, input logic [31:0] d, input logic [2:0] h,
                      input logic [15:0] ix, input logic fr);
    proc_valid = 1'b1;
    proc_addr  = a;
    tick;
    tick;
    comp_resp_valid = 1'b1;
    comp_resp_hit   = 1'b0;
    tick;
    comp_resp_valid = 1'b0;
    chk("miss_ic_req_valid", 64'(ic_req_valid), 64'd1);
    chk("miss_ic_req_addr", 64'(ic_req_addr), 64'(a));
    tick;
    ic_resp_valid  = 1'b1;
    ic_resp_rdata  = d;
    dict_probe_hit = h;
    dict_probe_idx = ix;
    fill_ready     = fr;
    #1 chk("miss_dict_probe", 64'(dict_probe), 64'(d));
    tick;
    ic_resp_valid = 1'b0;
    fill_ready    = 1'b0;
    chk("miss_proc_ready", 64'(proc_ready), 64'd1);
    chk("miss_proc_rdata", 64'(proc_rdata), 64'(d));
    proc_valid = 1'b0;
    tick;
  endtask
  task automatic pop_chk(input string tag, input logic [31:0] a);
    chk({tag, "_valid"}, 64'(fill_valid), 64'd1);
    chk({tag, "_addr"}, 64'(fill_addr), 64'(a));
    fill_ready = 1'b1;
    tick;
    fill_ready = 1'b0;
  endtask
  logic [31:0] exp_drain [4];
  initial begin
    tick;
    tick;
    chk("rst_proc_ready", 64'(proc_ready), 64'd0);
    chk("rst_comp_req", 64'(comp_req_valid), 64'd0);
    chk("rst_ic_req", 64'(ic_req_valid), 64'd0);
    chk("rst_fill_valid", 64'(fill_valid), 64'd0);
    chk("rst_outs", {proc_rdata, fill_addr}, 64'd0);
    chk("rst_keys", {dict_key, dict_probe, fill_idx}, 64'd0);
    reset = 1'b0;
    tick;
    // compressed hit
    proc_valid = 1'b1;
    proc_addr  = 32'h100;
    tick;
    chk("hit_comp_req_valid", 64'(comp_req_valid), 64'd1);
    chk("hit_comp_req_addr", 64'(comp_req_addr), 64'h100);
    tick;
    chk("hit_comp_req_once", 64'(comp_req_valid), 64'd0);
    comp_resp_valid = 1'b1;
    comp_resp_hit   = 1'b1;
    comp_resp_idx   = 16'h00A5;
    tick;
    comp_resp_valid = 1'b0;
    comp_resp_hit   = 1'b0;
    chk("hit_dict_key", 64'(dict_key), 64'h00A5);
    chk("hit_not_ready_yet", 64'(proc_ready), 64'd0);
    dict_val = 32'h00100093;
    tick;
    chk("hit_proc_ready", 64'(proc_ready), 64'd1);
    chk("hit_proc_rdata", 64'(proc_rdata), 64'h00100093);
    chk("hit_no_ic_req", 64'(ic_req_valid), 64'd0);
    proc_valid = 1'b0;
    tick;
    chk("hit_ready_pulse", 64'(proc_ready), 64'd0);
    // miss, compressible
    miss(32'h100, 32'h00100093, 3'b111, 16'h0123, 1'b0);
    chk("fill1_valid", 64'(fill_valid), 64'd1);
    chk("fill1_addr", 64'(fill_addr), 64'h100);
    chk("fill1_idx", 64'(fill_idx), 64'h0123);
    fill_ready = 1'b1;
    tick;
    fill_ready = 1'b0;
    chk("fill1_drained", 64'(fill_valid), 64'd0);
    // miss, not compressible
    miss(32'h104, 32'h00200113, 3'b101, 16'h0055, 1'b0);
    chk("noncomp_fifo_empty", 64'(fill_valid), 64'd0);
    // fill FIFO overflow then simultaneous pop/push while full
    for (int i = 0; i < 5; i++) miss(32'h300 + 32'(4 * i), 32'h00100093, 3'b111, 16'(i), 1'b0);
    chk("full_head", 64'(fill_addr), 64'h300);
    miss(32'h314, 32'h00100093, 3'b111, 16'h0005, 1'b1);
    exp_drain[0] = 32'h304;
    exp_drain[1] = 32'h308;
    exp_drain[2] = 32'h30C;
    exp_drain[3] = 32'h314;
    for (int i = 0; i < 4; i++) pop_chk("full_drain", exp_drain[i]);
    chk("full_drained_empty", 64'(fill_valid), 64'd0);
    // duplicate suppression
    miss(32'h200, 32'h00100093, 3'b111, 16'h0077, 1'b0);
    miss(32'h200, 32'h00100093, 3'b111, 16'h0077, 1'b0);
    pop_chk("dup_head", 32'h200);
    chk("dup_single_entry", 64'(fill_valid), 64'd0);
    // leave one entry queued for the reset test
    miss(32'h400, 32'h00100093, 3'b111, 16'h0011, 1'b0);
    chk("pre_rst_fill", 64'(fill_valid), 64'd1);
`ifdef COMP_FETCH_STATS_EN
    chk("stat_comp_hits", 64'(stat_comp_hits), 64'd1);
    chk("stat_ic_fetches", 64'(stat_ic_fetches), 64'd11);
    chk("stat_fill_drops", 64'(stat_fill_drops), 64'd1);
`endif
    // reset while waiting on the icache
    proc_valid = 1'b1;
    proc_addr  = 32'h404;
    tick;
    tick;
    comp_resp_valid = 1'b1;
    comp_resp_hit   = 1'b0;
    tick;
    comp_resp_valid = 1'b0;
    tick;
    chk("rst_mid_in_ic_wait", 64'(dut.r_state === S_IC_WAIT), 64'd1);
    proc_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_mid_state_idle", 64'(dut.r_state === S_IDLE), 64'd1);
    chk("rst_mid_fifo_empty", 64'(fill_valid), 64'd0);
    ic_resp_valid  = 1'b1;
    ic_resp_rdata  = 32'hDEADBEEF;
    dict_probe_hit = 3'b111;
    tick;
    ic_resp_valid = 1'b0;
    chk("late_resp_no_ready", 64'(proc_ready), 64'd0);
    chk("late_resp_still_idle", 64'(dut.r_state === S_IDLE), 64'd1);
    chk("late_resp_no_fill", 64'(fill_valid), 64'd0);
`ifdef COMP_FETCH_STATS_EN
    chk("stat_cleared", {stat_comp_hits, stat_fill_drops}, 64'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
